// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
// VGA timing generator. A clock-enable divider sets the pixel rate; sync and blank
// decodes are registered from next-state counters so they align with x_pos/y_pos.
module vga_sync_gen #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int CLK_DIV     = 2,      // legal range 1..16
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic       SYNC_ON  = SYNC_ACTIVE;
    localparam logic       SYNC_OFF = ~SYNC_ACTIVE;

    function automatic logic in_window(input logic [9:0] v,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    function automatic logic sync_level(input logic active);
        return active ? SYNC_ON : SYNC_OFF;
    endfunction

    logic [3:0] div_cnt;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    logic       adv_p0;
    logic       h_wrap_p0;
    logic       v_wrap_p0;
    logic       frame_p0;
    logic [3:0] div_nxt_p0;
    logic [9:0] h_nxt_p0;
    logic [9:0] v_nxt_p0;

    // Stage p0: next-state counters; they move only on the divider terminal count
    always_comb begin
        adv_p0     = (div_cnt == DIV_LAST);
        h_wrap_p0  = (h_cnt == H_LAST);
        v_wrap_p0  = (v_cnt == V_LAST);
        div_nxt_p0 = adv_p0 ? 4'd0 : div_cnt + 4'd1;
        h_nxt_p0   = h_cnt;
        v_nxt_p0   = v_cnt;
        if (adv_p0) begin
            h_nxt_p0 = h_wrap_p0 ? 10'd0 : h_cnt + 10'd1;
            if (h_wrap_p0) begin
                v_nxt_p0 = v_wrap_p0 ? 10'd0 : v_cnt + 10'd1;
            end
        end
        frame_p0 = adv_p0 && h_wrap_p0 && v_wrap_p0;
    end

    // Stage p1: state and decodes, so hsync/vsync/video_on track x_pos/y_pos with zero skew
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= 4'd0;
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
            video_on    <= 1'b0;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
        end else begin
            div_cnt     <= div_nxt_p0;
            h_cnt       <= h_nxt_p0;
            v_cnt       <= v_nxt_p0;
            pixel_tick  <= adv_p0;
            frame_start <= frame_p0;
            video_on    <= (h_nxt_p0 < H_VIS) && (v_nxt_p0 < V_VIS);
            hsync       <= sync_level(in_window(h_nxt_p0, HS_START, HS_END));
            vsync       <= sync_level(in_window(v_nxt_p0, VS_START, VS_END));
        end
    end

    assign x_pos = h_cnt;
    assign y_pos = v_cnt;

endmodule

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
// Bench for vga_sync_gen: four instances (standard and reduced timings, divide 2 and 1)
// checked cycle by cycle against a closed-form scan model through a scoreboard queue.
module tb_vga_sync_gen;

    typedef struct packed {
        int   d;
        int   h_disp, h_fp, h_sw, h_bp;
        int   v_disp, v_fp, v_sw, v_bp;
        logic act;
    } cfg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rn   [4];
    logic       pt_w [4];
    logic [9:0] x_w  [4];
    logic [9:0] y_w  [4];
    logic       hs_w [4];
    logic       vs_w [4];
    logic       von_w[4];
    logic       fs_w [4];
    int         k    [4];

    logic [24:0] sb[$];
    int n_vec = 0;
    int n_mis = 0;

    vga_sync_gen #(.CLK_DIV(2)) u_std (
        .clk(clk), .reset(rn[0]), .pixel_tick(pt_w[0]), .x_pos(x_w[0]), .y_pos(y_w[0]),
        .hsync(hs_w[0]), .vsync(vs_w[0]), .video_on(von_w[0]), .frame_start(fs_w[0]));

    vga_sync_gen #(.CLK_DIV(1)) u_d1 (
        .clk(clk), .reset(rn[1]), .pixel_tick(pt_w[1]), .x_pos(x_w[1]), .y_pos(y_w[1]),
        .hsync(hs_w[1]), .vsync(vs_w[1]), .video_on(von_w[1]), .frame_start(fs_w[1]));

    vga_sync_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                   .CLK_DIV(2)) u_sm (
        .clk(clk), .reset(rn[2]), .pixel_tick(pt_w[2]), .x_pos(x_w[2]), .y_pos(y_w[2]),
        .hsync(hs_w[2]), .vsync(vs_w[2]), .video_on(von_w[2]), .frame_start(fs_w[2]));

    vga_sync_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                   .CLK_DIV(1), .SYNC_ACTIVE(1'b1)) u_sm1 (
        .clk(clk), .reset(rn[3]), .pixel_tick(pt_w[3]), .x_pos(x_w[3]), .y_pos(y_w[3]),
        .hsync(hs_w[3]), .vsync(vs_w[3]), .video_on(von_w[3]), .frame_start(fs_w[3]));

    // Edges seen since each instance left reset.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) k[i] <= rn[i] ? k[i] + 1 : 0;
    end

    function automatic cfg_t cfg_of(input int id);
        case (id)
            0:       return '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
            1:       return '{1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
            2:       return '{2, 8, 2, 3, 2, 6, 1, 2, 1, 1'b0};
            default: return '{1, 8, 2, 3, 2, 6, 1, 2, 1, 1'b1};
        endcase
    endfunction

    // Packed as {pixel_tick, x[9:0], y[9:0], hsync, vsync, video_on, frame_start}.
    function automatic logic [24:0] model(input int id, input int kk, input logic r);
        cfg_t c;
        int ht, vt, p, x, y;
        logic tick, hsa, vsa, von, fs;
        c = cfg_of(id);
        if (!r || kk == 0) return {1'b0, 10'd0, 10'd0, ~c.act, ~c.act, 1'b0, 1'b0};
        ht   = c.h_disp + c.h_fp + c.h_sw + c.h_bp;
        vt   = c.v_disp + c.v_fp + c.v_sw + c.v_bp;
        tick = (kk % c.d) == 0;
        p    = kk / c.d;
        x    = p % ht;
        y    = (p / ht) % vt;
        hsa  = (x >= c.h_disp + c.h_fp) && (x < c.h_disp + c.h_fp + c.h_sw);
        vsa  = (y >= c.v_disp + c.v_fp) && (y < c.v_disp + c.v_fp + c.v_sw);
        von  = (x < c.h_disp) && (y < c.v_disp);
        fs   = tick && (p > 0) && ((p % (ht * vt)) == 0);
        return {tick, 10'(x), 10'(y), hsa ? c.act : ~c.act, vsa ? c.act : ~c.act, von, fs};
    endfunction

    function automatic logic [24:0] obs(input int id);
        return {pt_w[id], x_w[id], y_w[id], hs_w[id], vs_w[id], von_w[id], fs_w[id]};
    endfunction

    task automatic step_push(input int id);
        @(posedge clk);
        #1;
        sb.push_back(model(id, k[id], rn[id]));
    endtask

    task automatic test_reset();
        logic [24:0] exp, got;
        int first_tick;
        logic [9:0] x_at_tick;
        first_tick = -1;
        x_at_tick  = 10'h3ff;
        for (int i = 0; i < 10; i++) begin
            step_push(0);
            @(negedge clk);
            exp = sb.pop_front(); got = obs(0);
            n_vec++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, got, exp);
            end
        end
        rn[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step_push(0);
            @(negedge clk);
            exp = sb.pop_front(); got = obs(0);
            n_vec++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL reset_release k=%0d got=%h exp=%h", k[0], got, exp);
            end
            if (pt_w[0] && first_tick < 0) begin
                first_tick = i;
                x_at_tick  = x_w[0];
            end
        end
        n_vec++;
        if (first_tick !== 2) begin
            n_mis++;
            $display("FAIL first_tick_latency got=%0d exp=2", first_tick);
        end
        n_vec++;
        if (x_at_tick !== 10'd1) begin
            n_mis++;
            $display("FAIL x_on_first_tick got=%0d exp=1", x_at_tick);
        end
    endtask

    task automatic test_line();
        logic [24:0] exp, got;
        logic [9:0] gx, gy, px, py;
        int hs_clks, hs_first_x, t1, t2, wraps;
        hs_clks = 0; hs_first_x = -1; t1 = -1; t2 = -1; wraps = 0;
        px = x_w[0]; py = y_w[0];
        for (int i = 0; i < 7000 && k[0] < 6200; i++) begin
            step_push(0);
            @(negedge clk);
            exp = sb.pop_front(); got = obs(0);
            n_vec++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL line_scan k=%0d got=%h exp=%h", k[0], got, exp);
            end
            gx = got[23:14]; gy = got[13:4];
            if (gy == 10'd1 && got[3] == 1'b0) begin
                hs_clks++;
                if (hs_first_x < 0) hs_first_x = int'(gx);
            end
            if (px == 10'd799 && gx == 10'd0) begin
                wraps++;
                n_vec++;
                if (gy !== py + 10'd1) begin
                    n_mis++;
                    $display("FAIL line_wrap_y got=%0d exp=%0d", gy, py + 10'd1);
                end
            end
            if (gx == 10'd0 && gy == 10'd1 && t1 < 0) t1 = k[0];
            if (gx == 10'd0 && gy == 10'd2 && t2 < 0) t2 = k[0];
            px = gx; py = gy;
        end
        n_vec++;
        if (hs_clks !== 192) begin
            n_mis++;
            $display("FAIL hsync_width_clks got=%0d exp=192", hs_clks);
        end
        n_vec++;
        if (hs_first_x !== 656) begin
            n_mis++;
            $display("FAIL hsync_start_x got=%0d exp=656", hs_first_x);
        end
        n_vec++;
        if (t2 - t1 !== 1600) begin
            n_mis++;
            $display("FAIL line_period got=%0d exp=1600", t2 - t1);
        end
        n_vec++;
        if (wraps !== 3) begin
            n_mis++;
            $display("FAIL line_wrap_count got=%0d exp=3", wraps);
        end
    endtask

    task automatic test_async_reset();
        logic [24:0] exp, got;
        int fs_cnt;
        fs_cnt = 0;
        n_vec++;
        if (x_w[0] !== 10'd700 || hs_w[0] !== 1'b0) begin
            n_mis++;
            $display("FAIL pre_abort_pos got x=%0d hs=%b exp x=700 hs=0", x_w[0], hs_w[0]);
        end
        #2;
        rn[0] = 1'b0;
        #1;
        sb.push_back(model(0, k[0], rn[0]));
        exp = sb.pop_front(); got = obs(0);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL async_abort got=%h exp=%h", got, exp);
        end
        for (int i = 0; i < 3; i++) begin
            step_push(0);
            @(negedge clk);
            exp = sb.pop_front(); got = obs(0);
            n_vec++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL abort_hold cyc=%0d got=%h exp=%h", i, got, exp);
            end
        end
        rn[0] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step_push(0);
            @(negedge clk);
            exp = sb.pop_front(); got = obs(0);
            n_vec++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL restart_scan k=%0d got=%h exp=%h", k[0], got, exp);
            end
            if (fs_w[0]) fs_cnt++;
        end
        n_vec++;
        if (fs_cnt !== 0) begin
            n_mis++;
            $display("FAIL restart_frame_start got=%0d exp=0", fs_cnt);
        end
    endtask

    task automatic test_frame_small();
        logic [24:0] exp, got;
        int fs_cnt, fs_k0, fs_k1, vs_clks, hits;
        int bx[5], by[5], bv[5];
        bx = '{7, 8, 0, 14, 0};
        by = '{5, 5, 6, 9, 0};
        bv = '{1, 0, 0, 0, 1};
        fs_cnt = 0; fs_k0 = -1; fs_k1 = -1; vs_clks = 0; hits = 0;
        rn[2] = 1'b1;
        for (int i = 0; i < 620; i++) begin
            step_push(2);
            @(negedge clk);
            exp = sb.pop_front(); got = obs(2);
            n_vec++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL small_frame_scan k=%0d got=%h exp=%h", k[2], got, exp);
            end
            if (fs_w[2]) begin
                fs_cnt++;
                if (fs_k0 < 0) fs_k0 = k[2];
                else if (fs_k1 < 0) fs_k1 = k[2];
            end
            if (vs_w[2] == 1'b0) vs_clks++;
            if (k[2] / 2 >= 150 && k[2] / 2 < 300) begin
                for (int j = 0; j < 5; j++) begin
                    if (int'(exp[23:14]) == bx[j] && int'(exp[13:4]) == by[j]) begin
                        hits++;
                        n_vec++;
                        if (von_w[2] !== bv[j][0]) begin
                            n_mis++;
                            $display("FAIL video_on_edge x=%0d y=%0d got=%b exp=%0d",
                                     bx[j], by[j], von_w[2], bv[j]);
                        end
                    end
                end
            end
        end
        n_vec++;
        if (fs_cnt !== 2) begin
            n_mis++;
            $display("FAIL small_frame_count got=%0d exp=2", fs_cnt);
        end
        n_vec++;
        if (fs_k1 - fs_k0 !== 300) begin
            n_mis++;
            $display("FAIL small_frame_period got=%0d exp=300", fs_k1 - fs_k0);
        end
        n_vec++;
        if (vs_clks !== 120) begin
            n_mis++;
            $display("FAIL small_vsync_clks got=%0d exp=120", vs_clks);
        end
        n_vec++;
        if (hits !== 10) begin
            n_mis++;
            $display("FAIL video_on_edge_hits got=%0d exp=10", hits);
        end
    endtask

    task automatic test_clkdiv1();
        logic [24:0] exp, got;
        int pt_hi, hs_clks, fs_cnt, fs_k0, fs_k1, vs_clks;
        pt_hi = 0; hs_clks = 0;
        rn[1] = 1'b1;
        for (int i = 0; i < 1700; i++) begin
            step_push(1);
            @(negedge clk);
            exp = sb.pop_front(); got = obs(1);
            n_vec++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL div1_scan k=%0d got=%h exp=%h", k[1], got, exp);
            end
            if (pt_w[1]) pt_hi++;
            if (y_w[1] == 10'd1 && hs_w[1] == 1'b0) hs_clks++;
        end
        n_vec++;
        if (pt_hi !== 1700) begin
            n_mis++;
            $display("FAIL div1_tick_high got=%0d exp=1700", pt_hi);
        end
        n_vec++;
        if (hs_clks !== 96) begin
            n_mis++;
            $display("FAIL div1_hsync_clks got=%0d exp=96", hs_clks);
        end
        fs_cnt = 0; fs_k0 = -1; fs_k1 = -1; vs_clks = 0;
        rn[3] = 1'b1;
        for (int i = 0; i < 460; i++) begin
            step_push(3);
            @(negedge clk);
            exp = sb.pop_front(); got = obs(3);
            n_vec++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL div1_small_scan k=%0d got=%h exp=%h", k[3], got, exp);
            end
            if (fs_w[3]) begin
                fs_cnt++;
                if (fs_k0 < 0) fs_k0 = k[3];
                else if (fs_k1 < 0) fs_k1 = k[3];
            end
            if (vs_w[3] == 1'b1) vs_clks++;
        end
        n_vec++;
        if (fs_cnt !== 3) begin
            n_mis++;
            $display("FAIL div1_frame_count got=%0d exp=3", fs_cnt);
        end
        n_vec++;
        if (fs_k1 - fs_k0 !== 150) begin
            n_mis++;
            $display("FAIL div1_frame_period got=%0d exp=150", fs_k1 - fs_k0);
        end
        n_vec++;
        if (vs_clks !== 90) begin
            n_mis++;
            $display("FAIL div1_vsync_high_clks got=%0d exp=90", vs_clks);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rn[i] = 1'b0;
        test_reset();
        test_line();
        test_async_reset();
        test_frame_small();
        test_clkdiv1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
